screen_sched: RTL
=================

# screen_sched

Time-shares the 16-bit hex display (`Screen`) between two value producers: the CPU memory-mapped output port (source A) and the debug monitor (source B). Each source posts a word through a valid/ready handshake into its own one-entry slot. A dwell/blank state machine rotates the display between sources that have posted. Backpressure guarantees every accepted word is shown for at least one full dwell. The block sits between the CPU/debug logic and `Screen.din`.

## Interface
- `DWELL`, 12_000_000: cycles a source is shown per turn (1 s at 12 MHz); legal range ≥ 2
- `BLANK`, 1_200_000: blank cycles inserted when switching sources; legal range ≥ 1
- `clk  in  1  system clock`
- `rst  in  1  reset, synchronous, active-high`
- `a_valid  in  1  source A word available`
- `a_data  in  16  source A word`
- `a_ready  out  1  source A slot can accept`
- `b_valid  in  1  source B word available`
- `b_data  in  16  source B word`
- `b_ready  out  1  source B slot can accept`
- `hold  in  1  freeze rotation (dwell counter stops)`
- `disp_data  out  16  word driven to `Screen.din`
- `disp_src  out  1  source on display: 0 = A, 1 = B`
- `disp_blank  out  1  display blanked; disp_data forced to 0`

## Operation
- Per-source slot state: `shadow[15:0]`, `have` (a word was ever accepted), `pending` (accepted but not yet loaded to the display).
- `x_ready = ~pending_x & ~rst`, combinational.
- Accept occurs on the edge where `x_valid & x_ready`. That edge writes `shadow` and sets `have` and `pending`. `have` clears only on reset.
- FSM states:
  - IDLE
    - Neither `have` set: stay in IDLE.
    - Else go to SHOW_A if `have_a`; otherwise go to SHOW_B (A has priority).
  - SHOW_A / SHOW_B
    - `dwell_cnt` counts 0..DWELL-1. It increments only when `hold = 0`.
    - At `dwell_cnt == DWELL-1` with `hold = 0`: if the other source has `have`, go to BLANK. Otherwise restart the dwell in the same state and reload.
  - BLANK
    - `blank_cnt` counts 0..BLANK-1, ignoring `hold`.
    - At BLANK-1, go to SHOW of the source not previously shown.
- Load: every entry into SHOW_x, including a dwell restart, registers `disp_data <= shadow_x` and `disp_src <= x`, and clears `pending_x`.
- Load and accept on the same edge for the same source: the accept wins. `pending_x` ends at 1, `shadow_x` holds the new word, and the display shows the old word.
- In BLANK: `disp_data = 0`, `disp_blank = 1`, and `disp_src` holds its last value.
- In IDLE: `disp_blank = 1`, `disp_data = 0`.
- Once both sources have `have` set, the display alternates A, BLANK, B, BLANK, … forever.
- Counter widths: `$clog2(DWELL)` and `$clog2(BLANK)`. Both counters clear on every state entry and never wrap past their terminal value.

## Timing
- Reset (any cycle, including mid-dwell or mid-blank) results:
  - State: IDLE; all `have`/`pending` = 0; both counters = 0.
  - Outputs: `disp_data = 0`, `disp_src = 0`, `disp_blank = 1`, `a_ready = b_ready = 0` while `rst` is high.
- After reset, `ready` is high in the first cycle with `rst` low.
- Latency: a word accepted on edge k while in IDLE appears on `disp_data` after edge k+1 (one cycle). In the same cycle `disp_blank` falls, and `x_ready` rises after edge k+1.
- `disp_data` is constant for exactly DWELL cycles per SHOW when `hold` stays 0. `hold` extends SHOW cycle-for-cycle.
- Single source: a new word accepted mid-dwell appears at the next dwell boundary (≤ DWELL cycles later), with no blank inserted.
- Simultaneous accepts on A and B are both taken on the same edge. IDLE resolves to SHOW_A.
- All outputs except `ready` are registered.

## Structure
- Package `screen_pkg`:
  - FSM state enum: IDLE, SHOW_A, SHOW_B, BLANK.
  - Source index constants: `SRC_A = 0`, `SRC_B = 1`.
  - Default DWELL/BLANK constants.
- Sub-module `screen_slot`:
  - Contents: shadow, `have`, `pending`, the ready logic, and a `load` input that clears `pending`.
  - Instantiated twice.
- Top level holds the FSM, both counters and the output registers.

## Test plan (DWELL=4, BLANK=2)
- Reset, then A posts 0x1234 for one cycle → `a_ready` low the next cycle. `disp_data = 0x1234`, `disp_src = 0`, `disp_blank = 0` one cycle after the accept. `a_ready` high again the cycle after.
- A holds `a_valid` with 0xBEEF while 0x1234 is pending → no accept until the load. 0xBEEF appears at the next dwell boundary, 4 cycles after 0x1234 appeared.
- A posts 0x1111 and B posts 0x2222 on the same edge → sequence is 0x1111 ×4, blank ×2 (`disp_data = 0`), 0x2222 ×4, blank ×2, 0x1111, …
- `hold` = 1 for 10 cycles mid-SHOW_A with B `have` set → SHOW_A lasts 14 cycles. A `hold` asserted during BLANK does not stretch the blank (still 2 cycles).
- Accept on A coincides with the dwell-restart load of A → display shows the old word. `a_ready` stays low, and the new word appears 4 cycles later.
- Assert `rst` for one cycle mid-dwell with both sources active → next cycle `disp_blank = 1`, `disp_data = 0`, both `ready` = 1, and the FSM stays in IDLE until a new post.

Source files
------------

// File: rtl/screen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : screen_pkg
// Description : Shared types and constants for the screen time-share block.
// Revision    : 1.0 - initial release
// ============================================================================
package screen_pkg;

    // Width of the words posted by each source and shown on the display
    localparam int DATA_W = 16;

    // Default timing: 1 s dwell and 0.1 s blank at 12 MHz
    localparam int DEFAULT_DWELL = 12_000_000;
    localparam int DEFAULT_BLANK = 1_200_000;

    // Source indices as they appear on disp_src
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Display rotation states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW_A = 2'd1,
        ST_SHOW_B = 2'd2,
        ST_BLANK  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/screen_slot.sv
`default_nettype none
// ============================================================================
// Module      : screen_slot
// Description : One-entry posting slot for a display source. Holds the last
//               accepted word, remembers that a word was ever posted, and
//               back-pressures until the word has been loaded to the display.
// Revision    : 1.0 - initial release
// ============================================================================
module screen_slot
    import screen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_load,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_shadow,
    output logic              o_have
);

    logic [DATA_W-1:0] r_shadow;
    logic              r_have;
    logic              r_pending;
    logic              w_accept;

    // Ready only while no word is waiting to be shown, and never during reset
    assign o_ready  = ~r_pending & ~rst;
    assign w_accept = i_valid & o_ready;

    // Capture accepted words; an accept on the same edge as a load wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_have    <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_shadow  <= i_data;
            r_have    <= 1'b1;
            r_pending <= 1'b1;
        end else if (i_load) begin
            r_pending <= 1'b0;
        end
    end

    assign o_shadow = r_shadow;
    assign o_have   = r_have;

endmodule
`default_nettype wire

// File: rtl/screen_sched.sv
`default_nettype none
// ============================================================================
// Module      : screen_sched
// Description : Time-shares the hex display between the CPU output port
//               (source A) and the debug monitor (source B) using a
//               dwell/blank rotation. Every accepted word is shown for at
//               least one full dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module screen_sched
    import screen_pkg::*;
#(
    parameter int DWELL = DEFAULT_DWELL,
    parameter int BLANK = DEFAULT_BLANK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              hold,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_src,
    output logic              disp_blank
);

    // Counter widths; a single-cycle blank still needs one bit of storage
    localparam int c_DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int c_BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);
    localparam logic [c_BW-1:0] c_BLANK_LAST = c_BW'(BLANK - 1);

    localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ST_SHOW_A = ST_SHOW_A;
    localparam logic [1:0] c_ST_SHOW_B = ST_SHOW_B;
    localparam logic [1:0] c_ST_BLANK  = ST_BLANK;

    logic [1:0]        r_state;
    logic [c_DW-1:0]   r_dwell_cnt;
    logic [c_BW-1:0]   r_blank_cnt;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_src;
    logic              r_disp_blank;

    logic [DATA_W-1:0] w_shadow_a;
    logic [DATA_W-1:0] w_shadow_b;
    logic              w_have_a;
    logic              w_have_b;
    logic              w_load_a;
    logic              w_load_b;
    logic              w_to_blank;
    logic              w_dwell_done;
    logic              w_blank_done;

    screen_slot u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (a_valid),
        .i_data   (a_data),
        .i_load   (w_load_a),
        .o_ready  (a_ready),
        .o_shadow (w_shadow_a),
        .o_have   (w_have_a)
    );

    screen_slot u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (b_valid),
        .i_data   (b_data),
        .i_load   (w_load_b),
        .o_ready  (b_ready),
        .o_shadow (w_shadow_b),
        .o_have   (w_have_b)
    );

    assign w_dwell_done = (r_dwell_cnt == c_DWELL_LAST) & ~hold;
    assign w_blank_done = (r_blank_cnt == c_BLANK_LAST);

    // Decide which source (if any) gets loaded this edge, or whether to blank
    always_comb begin
        w_load_a   = 1'b0;
        w_load_b   = 1'b0;
        w_to_blank = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_have_a)      w_load_a = 1'b1;
                else if (w_have_b) w_load_b = 1'b1;
            end
            c_ST_SHOW_A: begin
                if (w_dwell_done) begin
                    if (w_have_b) w_to_blank = 1'b1;
                    else          w_load_a   = 1'b1;
                end
            end
            c_ST_SHOW_B: begin
                if (w_dwell_done) begin
                    if (w_have_a) w_to_blank = 1'b1;
                    else          w_load_b   = 1'b1;
                end
            end
            default: begin
                if (w_blank_done) begin
                    if (r_disp_src == SRC_A) w_load_b = 1'b1;
                    else                     w_load_a = 1'b1;
                end
            end
        endcase
    end

    // State, counters and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_dwell_cnt  <= '0;
            r_blank_cnt  <= '0;
            r_disp_data  <= '0;
            r_disp_src   <= SRC_A;
            r_disp_blank <= 1'b1;
        end else if (w_load_a) begin
            r_state      <= c_ST_SHOW_A;
            r_dwell_cnt  <= '0;
            r_blank_cnt  <= '0;
            r_disp_data  <= w_shadow_a;
            r_disp_src   <= SRC_A;
            r_disp_blank <= 1'b0;
        end else if (w_load_b) begin
            r_state      <= c_ST_SHOW_B;
            r_dwell_cnt  <= '0;
            r_blank_cnt  <= '0;
            r_disp_data  <= w_shadow_b;
            r_disp_src   <= SRC_B;
            r_disp_blank <= 1'b0;
        end else if (w_to_blank) begin
            r_state      <= c_ST_BLANK;
            r_dwell_cnt  <= '0;
            r_blank_cnt  <= '0;
            r_disp_data  <= '0;
            r_disp_blank <= 1'b1;
        end else begin
            case (r_state)
                c_ST_SHOW_A, c_ST_SHOW_B: begin
                    if (!hold) r_dwell_cnt <= r_dwell_cnt + 1'b1;
                end
                c_ST_BLANK: begin
                    r_blank_cnt <= r_blank_cnt + 1'b1;
                end
                default: begin
                    r_dwell_cnt <= '0;
                    r_blank_cnt <= '0;
                end
            endcase
        end
    end

    assign disp_data  = r_disp_data;
    assign disp_src   = r_disp_src;
    assign disp_blank = r_disp_blank;

endmodule
`default_nettype wire
